// File: rtl/reg_block_xfer_pkg.sv
// Shared types and defaults for the CHIP-8 FX55/FX65
// block register/memory transfer sequencer.
package reg_block_xfer_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 8;
    localparam int IDX_W_DEF  = 4;

    localparam logic DIR_STORE = 1'b0;
    localparam logic DIR_LOAD  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RF_WAIT,
        S_MEM_WR,
        S_MEM_RD,
        S_RF_WR,
        S_FIN
    } state_t;

endpackage

// File: rtl/reg_block_xfer.sv
// FX55/FX65 sequencer: walks V0..VX against [I..I+X],
// owning the register file lines and the memory request.
module reg_block_xfer
    import reg_block_xfer_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int IDX_W     = IDX_W_DEF,
    parameter int RF_RD_LAT = 1,
    parameter bit I_INCR    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dir,
    input  logic [IDX_W-1:0]  last_idx,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] i_next,
    output logic [IDX_W-1:0]  rf_sel,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_we,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int LAT   = (RF_RD_LAT < 1) ? 1 : RF_RD_LAT;
    localparam int CNT_W = (LAT < 2) ? 1 : $clog2(LAT);

    state_t            state, state_n;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  x_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  cnt_lat;
    logic [DATA_W-1:0] rf_wdata_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [ADDR_W-1:0] i_next_q;

    logic last;
    logic accept;
    logic adv;
    logic cnt_inc;
    logic cap_rf;
    logic cap_mem;
    logic to_fin;

    assign last = (idx == x_q);

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        adv     = 1'b0;
        cnt_inc = 1'b0;
        cap_rf  = 1'b0;
        cap_mem = 1'b0;
        to_fin  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = (dir == DIR_STORE) ? S_RF_WAIT : S_MEM_RD;
                end
            end
            S_RF_WAIT: begin
                if (cnt_lat == CNT_W'(LAT - 1)) begin
                    cap_rf  = 1'b1;
                    state_n = S_MEM_WR;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_MEM_WR: begin
                if (mem_ack) begin
                    if (last) begin
                        to_fin  = 1'b1;
                        state_n = S_FIN;
                    end else begin
                        adv     = 1'b1;
                        state_n = S_RF_WAIT;
                    end
                end
            end
            S_MEM_RD: begin
                if (mem_ack) begin
                    cap_mem = 1'b1;
                    state_n = S_RF_WR;
                end
            end
            S_RF_WR: begin
                if (last) begin
                    to_fin  = 1'b1;
                    state_n = S_FIN;
                end else begin
                    adv     = 1'b1;
                    state_n = S_MEM_RD;
                end
            end
            S_FIN: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx     <= '0;
            x_q     <= '0;
            base_q  <= '0;
            addr    <= '0;
            cnt_lat <= '0;
        end else if (accept) begin
            idx     <= '0;
            x_q     <= last_idx;
            base_q  <= base_addr;
            addr    <= base_addr;
            cnt_lat <= '0;
        end else if (adv) begin
            idx     <= idx + IDX_W'(1);
            addr    <= addr + ADDR_W'(1);
            cnt_lat <= '0;
        end else if (to_fin) begin
            // idle select back at V0 so the next store sees it settled
            idx     <= '0;
        end else if (cnt_inc) begin
            cnt_lat <= cnt_lat + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_wdata_q  <= '0;
            mem_wdata_q <= '0;
            i_next_q    <= '0;
        end else begin
            if (cap_rf) begin
                mem_wdata_q <= rf_rdata;
            end
            if (cap_mem) begin
                rf_wdata_q <= mem_rdata;
            end
            if (to_fin) begin
                i_next_q <= I_INCR ? base_q + ADDR_W'(x_q) + ADDR_W'(1)
                                   : base_q;
            end
        end
    end

    assign busy      = (state != S_IDLE) && (state != S_FIN);
    assign done      = (state == S_FIN);
    assign rf_we     = (state == S_RF_WR);
    assign mem_req   = (state == S_MEM_WR) || (state == S_MEM_RD);
    assign mem_we    = (state == S_MEM_WR);
    assign mem_addr  = addr;
    assign mem_wdata = mem_wdata_q;
    assign rf_wdata  = rf_wdata_q;
    assign i_next    = i_next_q;

    // register read is registered: aim at the next element while the
    // write is still outstanding so its data is ready in RF_WAIT
    assign rf_sel = (state == S_MEM_WR && !last) ? idx + IDX_W'(1) : idx;

endmodule

// File: tb/tb_reg_block_xfer.sv
// Scoreboard bench for reg_block_xfer: directed FX55/FX65
// transfers with a memory/register-file model.
module tb_reg_block_xfer;
    import reg_block_xfer_pkg::*;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          dir = 1'b0;
    logic [IW-1:0] last_idx = '0;
    logic [AW-1:0] base_addr = '0;
    logic          busy, done, rf_we, mem_req, mem_we, mem_ack;
    logic [AW-1:0] i_next, mem_addr;
    logic [IW-1:0] rf_sel;
    logic [DW-1:0] rf_wdata, rf_rdata, mem_wdata, mem_rdata;

    logic          start0 = 1'b0;
    logic          dir0 = 1'b0;
    logic [IW-1:0] last_idx0 = '0;
    logic [AW-1:0] base_addr0 = '0;
    logic          busy0, done0, rf_we0, mem_req0, mem_we0, mem_ack0;
    logic [AW-1:0] i_next0, mem_addr0;
    logic [IW-1:0] rf_sel0;
    logic [DW-1:0] rf_wdata0, mem_wdata0;
    logic [DW-1:0] rf_rdata0 = 8'h5A;
    logic [DW-1:0] mem_rdata0 = 8'h00;

    always #5 clk = ~clk;

    reg_block_xfer dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir),
        .last_idx(last_idx), .base_addr(base_addr),
        .busy(busy), .done(done), .i_next(i_next),
        .rf_sel(rf_sel), .rf_wdata(rf_wdata), .rf_we(rf_we),
        .rf_rdata(rf_rdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    reg_block_xfer #(.I_INCR(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .dir(dir0),
        .last_idx(last_idx0), .base_addr(base_addr0),
        .busy(busy0), .done(done0), .i_next(i_next0),
        .rf_sel(rf_sel0), .rf_wdata(rf_wdata0), .rf_we(rf_we0),
        .rf_rdata(rf_rdata0), .mem_req(mem_req0), .mem_we(mem_we0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .mem_ack(mem_ack0), .mem_rdata(mem_rdata0)
    );

    logic [DW-1:0] mem  [0:4095];
    logic [DW-1:0] regs [0:15];
    logic          pm_we = 1'b0;
    logic [AW-1:0] pm_addr = '0;
    logic [DW-1:0] pm_data = '0;
    logic          pr_we = 1'b0;
    logic [IW-1:0] pr_idx = '0;
    logic [DW-1:0] pr_data = '0;
    int            wcnt = 0;
    int            wait_cfg = 0;
    logic          force_ack = 1'b0;

    assign mem_ack   = force_ack | (mem_req && wcnt == wait_cfg);
    assign mem_rdata = mem[mem_addr];
    assign mem_ack0  = mem_req0;

    always @(posedge clk) begin
        if (pm_we) mem[pm_addr] <= pm_data;
        else if (mem_req && mem_ack && mem_we) mem[mem_addr] <= mem_wdata;
    end

    always @(posedge clk) begin
        if (pr_we) regs[pr_idx] <= pr_data;
        else if (rf_we) regs[rf_sel] <= rf_wdata;
        rf_rdata <= regs[rf_sel];
    end

    always @(posedge clk) begin
        if (mem_req && !mem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] data;
    } mexp_t;
    typedef struct {
        logic [IW-1:0] sel;
        logic [DW-1:0] data;
    } rexp_t;

    mexp_t         mq[$];
    rexp_t         rq[$];
    logic [AW-1:0] dq[$];
    int checks = 0;
    int failures = 0;
    int acc_cnt = 0;
    int done0_cnt = 0;
    int wr0_cnt = 0;
    logic [AW-1:0] wr0_last = '0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    initial begin : monitor
        logic          prev_we;
        logic          pend;
        logic [AW-1:0] paddr;
        logic          pwe;
        logic [DW-1:0] pwd;
        mexp_t         me;
        rexp_t         re;
        logic [AW-1:0] de;
        prev_we = 1'b0;
        pend = 1'b0;
        paddr = '0;
        pwe = 1'b0;
        pwd = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend = 1'b0;
                prev_we = 1'b0;
            end else begin
                if (busy) begin
                    chk("excl_rfwe_req", 64'(rf_we && mem_req), 64'(0));
                    chk("rfwe_b2b", 64'(rf_we && prev_we), 64'(0));
                end
                if (pend && mem_req) begin
                    chk("stable_addr", 64'(mem_addr), 64'(paddr));
                    chk("stable_we", 64'(mem_we), 64'(pwe));
                    if (pwe) chk("stable_wd", 64'(mem_wdata), 64'(pwd));
                end
                if (mem_req && mem_ack) begin
                    acc_cnt++;
                    if (mq.size() == 0) unexpected("mem_xfer");
                    else begin
                        me = mq.pop_front();
                        chk("mem_addr", 64'(mem_addr), 64'(me.addr));
                        chk("mem_we", 64'(mem_we), 64'(me.we));
                        if (me.we)
                            chk("mem_wdata", 64'(mem_wdata), 64'(me.data));
                    end
                end
                pend  = mem_req && !mem_ack;
                paddr = mem_addr;
                pwe   = mem_we;
                pwd   = mem_wdata;
                if (rf_we) begin
                    if (rq.size() == 0) unexpected("rf_write");
                    else begin
                        re = rq.pop_front();
                        chk("rf_sel", 64'(rf_sel), 64'(re.sel));
                        chk("rf_wdata", 64'(rf_wdata), 64'(re.data));
                    end
                end
                if (done) begin
                    if (dq.size() == 0) unexpected("done");
                    else begin
                        de = dq.pop_front();
                        chk("i_next", 64'(i_next), 64'(de));
                    end
                end
                prev_we = rf_we;
                if (done0) done0_cnt++;
                if (mem_req0 && mem_ack0) begin
                    wr0_cnt++;
                    wr0_last = mem_addr0;
                    chk("dut0_wdata", 64'(mem_wdata0), 64'(8'h5A));
                end
            end
        end
    end

    task automatic set_mem(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        pm_we = 1'b1;
        pm_addr = a;
        pm_data = d;
        @(negedge clk);
        pm_we = 1'b0;
    endtask

    task automatic set_reg(input logic [IW-1:0] i, input logic [DW-1:0] d);
        @(negedge clk);
        pr_we = 1'b1;
        pr_idx = i;
        pr_data = d;
        @(negedge clk);
        pr_we = 1'b0;
    endtask

    task automatic push_m(input logic [AW-1:0] a, input logic w,
                          input logic [DW-1:0] d);
        mexp_t e;
        e.addr = a;
        e.we = w;
        e.data = d;
        mq.push_back(e);
    endtask

    task automatic push_r(input logic [IW-1:0] s, input logic [DW-1:0] d);
        rexp_t e;
        e.sel = s;
        e.data = d;
        rq.push_back(e);
    endtask

    task automatic go(input logic d, input logic [IW-1:0] x,
                      input logic [AW-1:0] b);
        @(negedge clk);
        start = 1'b1;
        dir = d;
        last_idx = x;
        base_addr = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        dir = ~d;
        last_idx = ~x;
        base_addr = ~b;
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = 0;
        for (int n = 1; n <= budget && lat == 0; n++) begin
            @(negedge clk);
            #1;
            if (done) lat = n;
        end
        if (lat == 0) unexpected("done_timeout");
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin : stim
        int lat;
        int base_acc;
        int hit;
        logic [DW-1:0] t2v [4];
        t2v = '{8'h11, 8'h22, 8'h33, 8'h44};

        repeat (3) @(negedge clk);
        chk("reset_outs", {busy, done, rf_we, mem_req, mem_we, rf_sel,
            rf_wdata, mem_addr, mem_wdata, i_next}, 64'(0));
        chk("reset_dut0", {busy0, done0, mem_req0, i_next0}, 64'(0));
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // FX55 X=3 at 0x300, zero-wait
        for (int i = 0; i < 4; i++) set_reg(IW'(i), t2v[i]);
        repeat (2) @(negedge clk);
        wait_cfg = 0;
        for (int i = 0; i < 4; i++) push_m(AW'(12'h300 + i), 1'b1, t2v[i]);
        dq.push_back(12'h304);
        go(DIR_STORE, 4'd3, 12'h300);
        chk("busy_after_start", 64'(busy), 64'(1));
        wait_done(200, lat);
        chk("store_lat", 64'(lat), 64'(9));
        chk("busy_at_done", 64'(busy), 64'(0));
        repeat (3) @(negedge clk);
        chk("done_pulse", 64'(done), 64'(0));
        chk("i_next_held", 64'(i_next), 64'(12'h304));
        for (int i = 0; i < 4; i++)
            chk("mem_store", 64'(mem[12'h300 + i]), 64'(t2v[i]));

        // FX65 X=0 at 0x200
        set_mem(12'h200, 8'hAB);
        push_m(12'h200, 1'b0, 8'h00);
        push_r(4'd0, 8'hAB);
        dq.push_back(12'h201);
        go(DIR_LOAD, 4'd0, 12'h200);
        wait_done(200, lat);
        chk("load_lat", 64'(lat), 64'(3));

        // FX65 X=15 at 0xFFE with 3 wait states, wrapping address
        for (int i = 0; i < 16; i++)
            set_mem(AW'(12'hFFE + i), DW'(8'hC0 + i));
        wait_cfg = 3;
        for (int i = 0; i < 16; i++) begin
            push_m(AW'(12'hFFE + i), 1'b0, 8'h00);
            push_r(IW'(i), DW'(8'hC0 + i));
        end
        dq.push_back(12'h00E);
        go(DIR_LOAD, 4'd15, 12'hFFE);
        wait_done(2000, lat);
        chk("load_wait_lat", 64'(lat), 64'(81));

        // stray ack in IDLE
        wait_cfg = 0;
        @(negedge clk);
        force_ack = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stray_ack", {busy, mem_req, rf_we, done}, 64'(0));
        end
        force_ack = 1'b0;

        // I_INCR=0 instance, start pulsed while busy
        @(negedge clk);
        start0 = 1'b1;
        dir0 = DIR_STORE;
        last_idx0 = 4'd2;
        base_addr0 = 12'h400;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        start0 = 1'b1;
        dir0 = DIR_LOAD;
        last_idx0 = 4'hF;
        base_addr0 = 12'h123;
        @(negedge clk);
        start0 = 1'b0;
        repeat (20) @(negedge clk);
        chk("dut0_done_cnt", 64'(done0_cnt), 64'(1));
        chk("dut0_wr_cnt", 64'(wr0_cnt), 64'(3));
        chk("dut0_last_addr", 64'(wr0_last), 64'(12'h402));
        chk("dut0_i_next", 64'(i_next0), 64'(12'h400));

        // reset during 3rd element of FX55 X=5
        for (int i = 0; i < 6; i++) set_reg(IW'(i), DW'(8'h60 + i));
        repeat (2) @(negedge clk);
        wait_cfg = 2;
        push_m(12'h500, 1'b1, 8'h60);
        push_m(12'h501, 1'b1, 8'h61);
        base_acc = acc_cnt;
        go(DIR_STORE, 4'd5, 12'h500);
        hit = 0;
        for (int n = 0; n < 200 && hit == 0; n++) begin
            @(negedge clk);
            #1;
            if (acc_cnt == base_acc + 2 && mem_req) hit = 1;
        end
        if (hit == 0) unexpected("third_elem_timeout");
        #2;
        rst = 1'b0;
        #1;
        chk("midreset_outs", {busy, done, rf_we, mem_req, mem_we, rf_sel,
            rf_wdata, mem_addr, mem_wdata, i_next}, 64'(0));
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_reset_idle", {busy, done, mem_req, rf_we}, 64'(0));
        end
        chk("mq_after_reset", 64'(mq.size()), 64'(0));

        wait_cfg = 0;
        push_m(12'h600, 1'b1, 8'h60);
        push_m(12'h601, 1'b1, 8'h61);
        dq.push_back(12'h602);
        go(DIR_STORE, 4'd1, 12'h600);
        wait_done(200, lat);
        chk("restart_lat", 64'(lat), 64'(5));
        repeat (4) @(negedge clk);

        chk("mq_empty", 64'(mq.size()), 64'(0));
        chk("rq_empty", 64'(rq.size()), 64'(0));
        chk("dq_empty", 64'(dq.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
